mrv1_thread_sched: RTL and testbench

MRV1_THREAD_SCHED -- requirements
Module: mrv1_thread_sched

---
 rtl/mrv1_thread_sched_if.sv | 45 ++++
 rtl/mrv1_thread_sched.sv | 110 +++++++++++
 tb/tb_mrv1_thread_sched.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mrv1_thread_sched_if.sv
// rtl/mrv1_thread_sched_if.sv - request, issue, writeback and branch-resolve bundle for the thread scheduler
interface mrv1_thread_sched_if #(
  parameter int NUM_THREADS_P   = 8,
  parameter int NUM_FU_P        = 5,
  parameter int rf_addr_width_p = 5
);
  localparam int TID_W = $clog2(NUM_THREADS_P);

  logic [NUM_THREADS_P-1:0]                 thr_en_i;
  logic [NUM_THREADS_P-1:0]                 req_vld_i;
  logic [NUM_THREADS_P-1:0]                 req_rs0_vld_i;
  logic [NUM_THREADS_P-1:0]                 req_rs1_vld_i;
  logic [NUM_THREADS_P-1:0]                 req_rd_vld_i;
  logic [NUM_THREADS_P*rf_addr_width_p-1:0] req_rs0_addr_i;
  logic [NUM_THREADS_P*rf_addr_width_p-1:0] req_rs1_addr_i;
  logic [NUM_THREADS_P*rf_addr_width_p-1:0] req_rd_addr_i;
  logic [NUM_THREADS_P*NUM_FU_P-1:0]        req_fu_i;
  logic [NUM_THREADS_P-1:0]                 req_ctrl_i;
  logic [NUM_THREADS_P-1:0]                 req_gnt_o;
  logic [NUM_FU_P-1:0]                      fu_busy_i;
  logic                                     iss_vld_o;
  logic [TID_W-1:0]                         iss_tid_o;
  logic                                     iss_rdy_i;
  logic                                     wb_vld_i;
  logic [TID_W-1:0]                         wb_tid_i;
  logic [rf_addr_width_p-1:0]               wb_rd_addr_i;
  logic                                     br_res_vld_i;
  logic [TID_W-1:0]                         br_res_tid_i;

  modport master (
    output thr_en_i, req_vld_i, req_rs0_vld_i, req_rs1_vld_i, req_rd_vld_i,
           req_rs0_addr_i, req_rs1_addr_i, req_rd_addr_i, req_fu_i, req_ctrl_i,
           fu_busy_i, iss_rdy_i, wb_vld_i, wb_tid_i, wb_rd_addr_i,
           br_res_vld_i, br_res_tid_i,
    input  req_gnt_o, iss_vld_o, iss_tid_o
  );

  modport slave (
    input  thr_en_i, req_vld_i, req_rs0_vld_i, req_rs1_vld_i, req_rd_vld_i,
           req_rs0_addr_i, req_rs1_addr_i, req_rd_addr_i, req_fu_i, req_ctrl_i,
           fu_busy_i, iss_rdy_i, wb_vld_i, wb_tid_i, wb_rd_addr_i,
           br_res_vld_i, br_res_tid_i,
    output req_gnt_o, iss_vld_o, iss_tid_o
  );
endinterface

// File: rtl/mrv1_thread_sched.sv
// rtl/mrv1_thread_sched.sv - round-robin barrel-thread issue scheduler with per-thread
// register scoreboards and branch/jump stall tracking
module mrv1_thread_sched #(
  parameter int NUM_THREADS_P   = 8,
  parameter int NUM_FU_P        = 5,
  parameter int rf_addr_width_p = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  mrv1_thread_sched_if.slave   sched_if
);
  localparam int TID_W = $clog2(NUM_THREADS_P);
  localparam int AW    = rf_addr_width_p;
  localparam int RF_N  = 1 << AW;

  logic [NUM_THREADS_P-1:0][RF_N-1:0] sb_q, sb_d;
  logic [NUM_THREADS_P-1:0]           ctrl_pend_q, ctrl_pend_d;
  logic [TID_W-1:0]                   rr_ptr_q, rr_ptr_d;
  logic                               iss_vld_q, iss_vld_d;
  logic [TID_W-1:0]                   iss_tid_q, iss_tid_d;

  logic [NUM_THREADS_P-1:0] ready;
  logic [NUM_THREADS_P-1:0] req_gnt;
  logic                     gnt_en, gnt_any;
  logic [TID_W-1:0]         gnt_tid, scan_idx;
  logic [AW-1:0]            gnt_rd;

  // A writeback landing this cycle on the same thread/register is treated as already clear.
  for (genvar t = 0; t < NUM_THREADS_P; t++) begin : g_rdy
    logic [AW-1:0] rs0_a, rs1_a, rd_a;
    logic          wb_t, hz_rs0, hz_rs1, hz_rd, fu_blk;

    assign rs0_a  = sched_if.req_rs0_addr_i[t*AW +: AW];
    assign rs1_a  = sched_if.req_rs1_addr_i[t*AW +: AW];
    assign rd_a   = sched_if.req_rd_addr_i[t*AW +: AW];
    assign wb_t   = sched_if.wb_vld_i && (sched_if.wb_tid_i == TID_W'(t));
    assign hz_rs0 = sched_if.req_rs0_vld_i[t] && sb_q[t][rs0_a] &&
                    !(wb_t && (sched_if.wb_rd_addr_i == rs0_a));
    assign hz_rs1 = sched_if.req_rs1_vld_i[t] && sb_q[t][rs1_a] &&
                    !(wb_t && (sched_if.wb_rd_addr_i == rs1_a));
    assign hz_rd  = sched_if.req_rd_vld_i[t] && sb_q[t][rd_a] &&
                    !(wb_t && (sched_if.wb_rd_addr_i == rd_a));
    assign fu_blk = |(sched_if.req_fu_i[t*NUM_FU_P +: NUM_FU_P] & sched_if.fu_busy_i);
    assign ready[t] = sched_if.req_vld_i[t] && sched_if.thr_en_i[t] && !ctrl_pend_q[t] &&
                      !hz_rs0 && !hz_rs1 && !hz_rd && !fu_blk;
  end

  assign gnt_en = ~iss_vld_q | sched_if.iss_rdy_i;

  // First ready thread at or above rr_ptr; TID_W arithmetic wraps naturally.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_tid  = rr_ptr_q;
    scan_idx = '0;
    for (int i = 0; i < NUM_THREADS_P; i++) begin
      scan_idx = rr_ptr_q + TID_W'(i);
      if (!gnt_any && ready[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_tid = scan_idx;
      end
    end
    gnt_any = gnt_any & gnt_en & ~rst_i;
  end

  always_comb begin
    req_gnt = '0;
    if (gnt_any) req_gnt[gnt_tid] = 1'b1;
  end

  assign gnt_rd = sched_if.req_rd_addr_i[gnt_tid*AW +: AW];

  // Clears are applied before sets so a same-cycle set wins.
  always_comb begin
    sb_d        = sb_q;
    ctrl_pend_d = ctrl_pend_q;
    rr_ptr_d    = rr_ptr_q;
    iss_vld_d   = iss_vld_q;
    iss_tid_d   = iss_tid_q;
    if (sched_if.wb_vld_i)     sb_d[sched_if.wb_tid_i][sched_if.wb_rd_addr_i] = 1'b0;
    if (sched_if.br_res_vld_i) ctrl_pend_d[sched_if.br_res_tid_i] = 1'b0;
    if (gnt_en) iss_vld_d = gnt_any;
    if (gnt_any) begin
      iss_tid_d = gnt_tid;
      rr_ptr_d  = gnt_tid + 1'b1;
      if (sched_if.req_rd_vld_i[gnt_tid]) sb_d[gnt_tid][gnt_rd] = 1'b1;
      if (sched_if.req_ctrl_i[gnt_tid])   ctrl_pend_d[gnt_tid]  = 1'b1;
    end
    for (int t = 0; t < NUM_THREADS_P; t++) sb_d[t][0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sb_q        <= '0;
      ctrl_pend_q <= '0;
      rr_ptr_q    <= '0;
      iss_vld_q   <= 1'b0;
      iss_tid_q   <= '0;
    end else begin
      sb_q        <= sb_d;
      ctrl_pend_q <= ctrl_pend_d;
      rr_ptr_q    <= rr_ptr_d;
      iss_vld_q   <= iss_vld_d;
      iss_tid_q   <= iss_tid_d;
    end
  end

  assign sched_if.req_gnt_o = req_gnt;
  assign sched_if.iss_vld_o = iss_vld_q;
  assign sched_if.iss_tid_o = iss_tid_q;
endmodule

// File: tb/tb_mrv1_thread_sched.sv
// tb/tb_mrv1_thread_sched.sv - directed self-checking bench for mrv1_thread_sched
module tb_mrv1_thread_sched;
  localparam int T  = 8;
  localparam int FU = 5;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mrv1_thread_sched_if #(.NUM_THREADS_P(T), .NUM_FU_P(FU), .rf_addr_width_p(AW)) bus ();

  mrv1_thread_sched #(.NUM_THREADS_P(T), .NUM_FU_P(FU), .rf_addr_width_p(AW)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .sched_if(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_reqs();
    bus.req_vld_i      = '0;
    bus.req_rs0_vld_i  = '0;
    bus.req_rs1_vld_i  = '0;
    bus.req_rd_vld_i   = '0;
    bus.req_rs0_addr_i = '0;
    bus.req_rs1_addr_i = '0;
    bus.req_rd_addr_i  = '0;
    bus.req_fu_i       = '0;
    bus.req_ctrl_i     = '0;
  endtask

  task automatic set_req(input int tid, input logic rs0v, input logic [4:0] rs0,
                         input logic rs1v, input logic [4:0] rs1,
                         input logic rdv, input logic [4:0] rd,
                         input logic ctrl, input logic [4:0] fu);
    bus.req_vld_i[tid]                = 1'b1;
    bus.req_rs0_vld_i[tid]            = rs0v;
    bus.req_rs0_addr_i[tid*AW +: AW]  = rs0;
    bus.req_rs1_vld_i[tid]            = rs1v;
    bus.req_rs1_addr_i[tid*AW +: AW]  = rs1;
    bus.req_rd_vld_i[tid]             = rdv;
    bus.req_rd_addr_i[tid*AW +: AW]   = rd;
    bus.req_ctrl_i[tid]               = ctrl;
    bus.req_fu_i[tid*FU +: FU]        = fu;
  endtask

  initial begin
    clr_reqs();
    bus.thr_en_i     = '1;
    bus.fu_busy_i    = '0;
    bus.iss_rdy_i    = 1'b1;
    bus.wb_vld_i     = 1'b0;
    bus.wb_tid_i     = '0;
    bus.wb_rd_addr_i = '0;
    bus.br_res_vld_i = 1'b0;
    bus.br_res_tid_i = '0;
    for (int t = 0; t < T; t++) set_req(t, 0, 0, 0, 0, 0, 0, 0, 5'b00001);

    // reset state with every thread requesting
    tick();
    tick();
    chk("rst_gnt", bus.req_gnt_o, 0);
    chk("rst_vld", bus.iss_vld_o, 0);
    chk("rst_tid", bus.iss_tid_o, 0);

    // round robin 0..7,0
    rst = 1'b0;
    #1;
    for (int k = 0; k < 9; k++) begin
      chk("rr_gnt", bus.req_gnt_o, 32'd1 << (k % 8));
      tick();
      chk("rr_vld", bus.iss_vld_o, 1);
      chk("rr_tid", bus.iss_tid_o, k % 8);
    end
    clr_reqs();
    #1;
    chk("idle_gnt", bus.req_gnt_o, 0);
    tick();
    chk("idle_vld", bus.iss_vld_o, 0);

    // RAW hazard on T2 x5 with writeback bypass
    set_req(2, 0, 0, 0, 0, 1, 5, 0, 5'b00001);
    #1;
    chk("raw_gnt0", bus.req_gnt_o, 32'h04);
    tick();
    chk("raw_tid0", bus.iss_tid_o, 2);
    clr_reqs();
    set_req(2, 1, 5, 0, 0, 0, 0, 0, 5'b00001);
    #1;
    chk("raw_stall", bus.req_gnt_o, 0);
    tick();
    chk("raw_vld", bus.iss_vld_o, 0);
    bus.wb_vld_i = 1'b1; bus.wb_tid_i = 3'd3; bus.wb_rd_addr_i = 5'd5;
    #1;
    chk("raw_wrong_tid", bus.req_gnt_o, 0);
    tick();
    bus.wb_tid_i = 3'd2;
    #1;
    chk("raw_bypass", bus.req_gnt_o, 32'h04);
    tick();
    chk("raw_tid1", bus.iss_tid_o, 2);
    bus.wb_vld_i = 1'b0;
    #1;
    chk("raw_cleared", bus.req_gnt_o, 32'h04);
    clr_reqs();
    tick();

    // x0 never becomes pending
    set_req(4, 0, 0, 0, 0, 1, 0, 0, 5'b00001);
    #1;
    chk("x0_gnt", bus.req_gnt_o, 32'h10);
    tick();
    clr_reqs();
    set_req(4, 1, 0, 0, 0, 0, 0, 0, 5'b00001);
    #1;
    chk("x0_nohaz", bus.req_gnt_o, 32'h10);
    clr_reqs();
    tick();

    // set wins over same-cycle writeback clear
    set_req(1, 0, 0, 0, 0, 1, 7, 0, 5'b00001);
    bus.wb_vld_i = 1'b1; bus.wb_tid_i = 3'd1; bus.wb_rd_addr_i = 5'd7;
    #1;
    chk("sw_gnt", bus.req_gnt_o, 32'h02);
    tick();
    clr_reqs();
    bus.wb_vld_i = 1'b0;
    set_req(1, 0, 0, 1, 7, 0, 0, 0, 5'b00001);
    #1;
    chk("sw_held", bus.req_gnt_o, 0);
    clr_reqs();
    tick();
    bus.wb_vld_i = 1'b1;
    tick();
    bus.wb_vld_i = 1'b0;
    set_req(1, 0, 0, 1, 7, 0, 0, 0, 5'b00001);
    #1;
    chk("sw_clr", bus.req_gnt_o, 32'h02);
    clr_reqs();
    tick();

    // back-pressure (rr_ptr is 2 here)
    set_req(5, 0, 0, 0, 0, 0, 0, 0, 5'b00001);
    set_req(6, 0, 0, 0, 0, 0, 0, 0, 5'b00001);
    #1;
    chk("bp_gnt0", bus.req_gnt_o, 32'h20);
    tick();
    chk("bp_tid0", bus.iss_tid_o, 5);
    bus.iss_rdy_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_gnt", bus.req_gnt_o, 0);
      tick();
      chk("bp_vld", bus.iss_vld_o, 1);
      chk("bp_tid", bus.iss_tid_o, 5);
    end
    bus.iss_rdy_i = 1'b1;
    #1;
    chk("bp_release", bus.req_gnt_o, 32'h40);
    tick();
    chk("bp_tid1", bus.iss_tid_o, 6);
    clr_reqs();
    tick();
    chk("bp_drain", bus.iss_vld_o, 0);

    // control stall on T3 (rr_ptr is 7 here)
    set_req(3, 0, 0, 0, 0, 0, 0, 1, 5'b00010);
    #1;
    chk("br_gnt", bus.req_gnt_o, 32'h08);
    tick();
    clr_reqs();
    set_req(3, 0, 0, 0, 0, 0, 0, 0, 5'b00010);
    set_req(0, 0, 0, 0, 0, 0, 0, 0, 5'b00001);
    #1;
    chk("br_block", bus.req_gnt_o, 32'h01);
    tick();
    chk("br_block2", bus.req_gnt_o, 32'h01);
    bus.br_res_vld_i = 1'b1; bus.br_res_tid_i = 3'd3;
    #1;
    chk("br_same", bus.req_gnt_o, 32'h01);
    tick();
    bus.br_res_vld_i = 1'b0;
    #1;
    chk("br_elig", bus.req_gnt_o, 32'h08);
    bus.thr_en_i[3] = 1'b0;
    #1;
    chk("en_block", bus.req_gnt_o, 32'h01);
    bus.fu_busy_i = 5'b00001;
    #1;
    chk("fu_busy", bus.req_gnt_o, 0);
    bus.thr_en_i[3] = 1'b1;
    #1;
    chk("fu_other", bus.req_gnt_o, 32'h08);
    bus.fu_busy_i = '0;
    clr_reqs();
    tick();

    // asynchronous reset mid-run (rr_ptr is 1 here)
    set_req(6, 0, 0, 0, 0, 1, 9, 0, 5'b00001);
    #1;
    chk("mr_gnt", bus.req_gnt_o, 32'h40);
    tick();
    chk("mr_vld", bus.iss_vld_o, 1);
    bus.iss_rdy_i = 1'b0;
    clr_reqs();
    set_req(6, 1, 9, 0, 0, 0, 0, 0, 5'b00001);
    set_req(0, 0, 0, 0, 0, 0, 0, 0, 5'b00001);
    #1;
    chk("mr_hold", bus.req_gnt_o, 0);
    rst = 1'b1;
    #1;
    chk("mr_rst_vld", bus.iss_vld_o, 0);
    chk("mr_rst_tid", bus.iss_tid_o, 0);
    chk("mr_rst_gnt", bus.req_gnt_o, 0);
    tick();
    rst = 1'b0;
    bus.iss_rdy_i = 1'b1;
    set_req(0, 1, 5, 1, 3, 1, 5, 0, 5'b00001);
    #1;
    chk("post_rst_gnt", bus.req_gnt_o, 32'h01);
    tick();
    chk("post_rst_tid", bus.iss_tid_o, 0);
    chk("post_rst_sb", bus.req_gnt_o, 32'h40);
    clr_reqs();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
